// File: rtl/motor_cmd_spi_rx_if.sv
// SPI pin bundle between the host MCU (master) and the motor command receiver (slave).
interface motor_cmd_spi_rx_if;
  logic sck;
  logic cs_n;
  logic mosi;

  modport master (output sck, output cs_n, output mosi);
  modport slave  (input sck, input cs_n, input mosi);
endinterface

// File: rtl/motor_cmd_spi_rx.sv
// SPI slave receiving 3-byte motor command frames; drives sign/duty registers with a load strobe.
// Optional watchdog enabled by defining MOTOR_CMD_WDT_EN.
module motor_cmd_spi_rx #(
  parameter logic [6:0]  DUTY_MAX   = 7'd100,
  parameter logic [7:0]  CSUM_KEY   = 8'hA5,
  parameter logic [31:0] WDT_CYCLES = 32'd12_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  motor_cmd_spi_rx_if.slave        spi,
  output logic                     motor1_sign,
  output logic [6:0]               motor1_upperlimit,
  output logic                     motor2_sign,
  output logic [6:0]               motor2_upperlimit,
  output logic                     load,
  output logic                     cmd_valid,
  output logic                     frame_err,
  output logic [7:0]               err_count,
  output logic                     wdt_trip,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  sck_sr, cs_sr, mosi_sr;
  logic        sck_rise_q, cs_rise_q, cs_fall_q, mosi_q;
  logic [23:0] shreg;
  logic [4:0]  bit_cnt;
  logic        frame_ok;
  logic        csum_ok;

  assign dbg_state = state;
  assign csum_ok   = (shreg[7:0] == (shreg[23:16] ^ shreg[15:8] ^ CSUM_KEY));

  function automatic logic [6:0] clamp(input logic [6:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  // cs_n synchronizer resets low so a chip select already low at reset release
  // needs a fresh high-then-low transition before a frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sr     <= 3'b000;
      cs_sr      <= 3'b000;
      mosi_sr    <= 3'b000;
      sck_rise_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      sck_sr     <= {sck_sr[1:0], spi.sck};
      cs_sr      <= {cs_sr[1:0], spi.cs_n};
      mosi_sr    <= {mosi_sr[1:0], spi.mosi};
      sck_rise_q <= sck_sr[1] & ~sck_sr[2];
      cs_rise_q  <= cs_sr[1] & ~cs_sr[2];
      cs_fall_q  <= ~cs_sr[1] & cs_sr[2];
      mosi_q     <= mosi_sr[2];
    end
  end

`ifdef MOTOR_CMD_WDT_EN
  logic [31:0] wdt_cnt;
  logic        wdt_pend;
  logic        wdt_commit;

  assign wdt_pend = (wdt_cnt == WDT_CYCLES);

  // Saturates so a timeout deferred by a long frame is not lost to wraparound.
  always_ff @(posedge clk) begin
    if (reset || state == COMMIT) wdt_cnt <= 32'd0;
    else if (!wdt_pend)           wdt_cnt <= wdt_cnt + 32'd1;
  end
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_CYCLES;
  assign wdt_trip   = 1'b0;
`endif

  // load is high through COMMIT and HOLD; outputs only change on the edge ending COMMIT,
  // so the PWM stage sees stable values whenever load is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      shreg             <= 24'd0;
      bit_cnt           <= 5'd0;
      frame_ok          <= 1'b0;
      motor1_sign       <= 1'b0;
      motor1_upperlimit <= 7'd0;
      motor2_sign       <= 1'b0;
      motor2_upperlimit <= 7'd0;
      load              <= 1'b0;
      cmd_valid         <= 1'b0;
      frame_err         <= 1'b0;
      err_count         <= 8'd0;
`ifdef MOTOR_CMD_WDT_EN
      wdt_commit        <= 1'b0;
      wdt_trip          <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MOTOR_CMD_WDT_EN
          if (wdt_pend) begin
            state      <= COMMIT;
            load       <= 1'b1;
            wdt_commit <= 1'b1;
          end else
`endif
          if (cs_fall_q) begin
            shreg   <= 24'd0;
            bit_cnt <= 5'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise_q) begin
            // Verdict is registered on entry so frame_err is high during CHECK.
            frame_ok <= (bit_cnt == 5'd24) && csum_ok;
            if (!((bit_cnt == 5'd24) && csum_ok)) begin
              frame_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            state <= CHECK;
          end else if (sck_rise_q) begin
            shreg <= {shreg[22:0], mosi_q};
            if (bit_cnt != 5'd25) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        CHECK: begin
          if (frame_ok) begin
            state <= COMMIT;
            load  <= 1'b1;
`ifdef MOTOR_CMD_WDT_EN
            wdt_commit <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        COMMIT: begin
          state <= HOLD;
`ifdef MOTOR_CMD_WDT_EN
          if (wdt_commit) begin
            motor1_upperlimit <= 7'd0;
            motor2_upperlimit <= 7'd0;
            wdt_trip          <= 1'b1;
            wdt_commit        <= 1'b0;
          end else begin
            motor1_sign       <= shreg[23];
            motor1_upperlimit <= clamp(shreg[22:16]);
            motor2_sign       <= shreg[15];
            motor2_upperlimit <= clamp(shreg[14:8]);
            cmd_valid         <= 1'b1;
            wdt_trip          <= 1'b0;
          end
`else
          motor1_sign       <= shreg[23];
          motor1_upperlimit <= clamp(shreg[22:16]);
          motor2_sign       <= shreg[15];
          motor2_upperlimit <= clamp(shreg[14:8]);
          cmd_valid         <= 1'b1;
`endif
        end
        HOLD: begin
          load  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// Directed bench for motor_cmd_spi_rx: frames, clamping, error frames, mid-frame reset, saturation.
module tb_motor_cmd_spi_rx;

  logic       clk;
  logic       reset;
  logic       motor1_sign, motor2_sign;
  logic [6:0] motor1_upperlimit, motor2_upperlimit;
  logic       load, cmd_valid, frame_err, wdt_trip;
  logic [7:0] err_count;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [8:0] load_hist;
  logic [8:0] err_hist;
  logic [6:0] pre_m1;

  motor_cmd_spi_rx_if spi ();

  motor_cmd_spi_rx #(.WDT_CYCLES(32'd1000)) dut (
    .clk               (clk),
    .reset             (reset),
    .spi               (spi.slave),
    .motor1_sign       (motor1_sign),
    .motor1_upperlimit (motor1_upperlimit),
    .motor2_sign       (motor2_sign),
    .motor2_upperlimit (motor2_upperlimit),
    .load              (load),
    .cmd_valid         (cmd_valid),
    .frame_err         (frame_err),
    .err_count         (err_count),
    .wdt_trip          (wdt_trip),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame of n bits (MSB first from bits[n-1:0]), then records load and
  // frame_err at each of the 8 negedges after CS rises (index k follows posedge k-1).
  task automatic spi_send(input logic [31:0] bits, input int n);
    @(negedge clk);
    spi.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi.mosi = bits[i];
      repeat (4) @(negedge clk);
      spi.sck = 1'b1;
      repeat (4) @(negedge clk);
      spi.sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi.cs_n  = 1'b1;
    load_hist = '0;
    err_hist  = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      load_hist[k] = load;
      err_hist[k]  = frame_err;
      if (k == 5) pre_m1 = motor1_upperlimit;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_motors(input string tag, input logic s1, input logic [6:0] d1,
                              input logic s2, input logic [6:0] d2);
    check_val({tag, "_m1s"}, {31'd0, motor1_sign}, {31'd0, s1});
    check_val({tag, "_m1d"}, {25'd0, motor1_upperlimit}, {25'd0, d1});
    check_val({tag, "_m2s"}, {31'd0, motor2_sign}, {31'd0, s2});
    check_val({tag, "_m2d"}, {25'd0, motor2_upperlimit}, {25'd0, d2});
  endtask

  initial begin
    spi.sck  = 1'b0;
    spi.cs_n = 1'b1;
    spi.mosi = 1'b0;
    do_reset();
    @(negedge clk);

    check_motors("rst", 1'b0, 7'd0, 1'b0, 7'd0);
    check_val("rst_load", {31'd0, load}, 32'd0);
    check_val("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_err_count", {24'd0, err_count}, 32'd0);
    check_val("rst_wdt_trip", {31'd0, wdt_trip}, 32'd0);
    check_val("rst_state", {29'd0, dbg_state}, 32'd0);

    // 32 ^ C5 ^ A5 = 52
    spi_send(32'h0032C552, 24);
    check_val("f1_load_hist", {23'd0, load_hist}, 32'h060);
    check_val("f1_err_hist", {23'd0, err_hist}, 32'h000);
    check_val("f1_pre_commit_m1", {25'd0, pre_m1}, 32'd0);
    check_motors("f1", 1'b0, 7'd50, 1'b1, 7'd69);
    check_val("f1_cmd_valid", {31'd0, cmd_valid}, 32'd1);

    // 7F ^ FF ^ A5 = 25
    spi_send(32'h007FFF25, 24);
    check_motors("clamp7f", 1'b0, 7'd100, 1'b1, 7'd100);
    check_val("clamp7f_pre", {25'd0, pre_m1}, 32'd50);
    // 64 ^ E4 ^ A5 = 25
    spi_send(32'h0064E425, 24);
    check_motors("exact100", 1'b0, 7'd100, 1'b1, 7'd100);
    // 65 ^ 00 ^ A5 = C0
    spi_send(32'h006500C0, 24);
    check_motors("d101", 1'b0, 7'd100, 1'b0, 7'd0);

    spi_send(32'h0032C553, 24);
    check_val("badcs_err_hist", {23'd0, err_hist}, 32'h010);
    check_val("badcs_load_hist", {23'd0, load_hist}, 32'h000);
    check_val("badcs_err_count", {24'd0, err_count}, 32'd1);
    spi_send(32'h0032C552, 23);
    check_val("b23_err_hist", {23'd0, err_hist}, 32'h010);
    check_val("b23_err_count", {24'd0, err_count}, 32'd2);
    spi_send(32'h0032C552, 26);
    check_val("b26_err_hist", {23'd0, err_hist}, 32'h010);
    check_val("b26_load_hist", {23'd0, load_hist}, 32'h000);
    check_val("b26_err_count", {24'd0, err_count}, 32'd3);
    check_motors("bad_hold", 1'b0, 7'd100, 1'b0, 7'd0);
    check_val("bad_cmd_valid", {31'd0, cmd_valid}, 32'd1);

    // Reset after 12 bits with CS held low across reset release
    @(negedge clk);
    spi.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 23; i >= 12; i--) begin
      spi.mosi = i[0];
      repeat (4) @(negedge clk);
      spi.sck = 1'b1;
      repeat (4) @(negedge clk);
      spi.sck = 1'b0;
    end
    do_reset();
    repeat (10) @(negedge clk);
    check_motors("midrst", 1'b0, 7'd0, 1'b0, 7'd0);
    check_val("midrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_val("midrst_err_count", {24'd0, err_count}, 32'd0);
    check_val("midrst_load", {31'd0, load}, 32'd0);
    check_val("midrst_cs_low_idle", {29'd0, dbg_state}, 32'd0);
    spi.cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("midrst_cs_high_idle", {29'd0, dbg_state}, 32'd0);
    spi_send(32'h0032C552, 24);
    check_val("postrst_load_hist", {23'd0, load_hist}, 32'h060);
    check_motors("postrst", 1'b0, 7'd50, 1'b1, 7'd69);
    check_val("postrst_cmd_valid", {31'd0, cmd_valid}, 32'd1);
    check_val("postrst_wdt_trip", {31'd0, wdt_trip}, 32'd0);

    // 300 one-bit frames, a valid frame every 20 keeps any watchdog quiet
    for (int i = 0; i < 300; i++) begin
      spi_send(32'h1, 1);
      if (i % 20 == 19) spi_send(32'h0032C552, 24);
    end
    check_val("sat_err_count", {24'd0, err_count}, 32'd255);
    check_val("sat_cmd_valid", {31'd0, cmd_valid}, 32'd1);

`ifdef MOTOR_CMD_WDT_EN
    begin
      int t;
      // BC ^ 3C ^ A5 = 25
      spi_send(32'h00BC3C25, 24);
      check_motors("wdt_pre", 1'b1, 7'd60, 1'b0, 7'd60);
      t = 0;
      while (load !== 1'b1 && t < 1500) begin
        @(negedge clk);
        t++;
      end
      check_val("wdt_fired_in_time", {31'd0, t < 1500}, 32'd1);
      @(negedge clk);
      check_val("wdt_load_2nd", {31'd0, load}, 32'd1);
      @(negedge clk);
      check_val("wdt_load_end", {31'd0, load}, 32'd0);
      check_motors("wdt", 1'b1, 7'd0, 1'b0, 7'd0);
      check_val("wdt_trip_set", {31'd0, wdt_trip}, 32'd1);
      check_val("wdt_cmd_valid", {31'd0, cmd_valid}, 32'd1);
      spi_send(32'h0032C552, 24);
      check_val("wdt_trip_clr", {31'd0, wdt_trip}, 32'd0);
      check_motors("wdt_post", 1'b0, 7'd50, 1'b1, 7'd69);
    end
`else
    repeat (50) @(negedge clk);
    check_val("nowdt_trip", {31'd0, wdt_trip}, 32'd0);
    check_val("nowdt_hold_m1", {25'd0, motor1_upperlimit}, 32'd50);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_cmd_spi_rx.md
# motor_cmd_spi_rx

SPI slave command receiver feeding the dual-motor PWM controller. It receives 3-byte frames from the host MCU, carrying direction and duty for both motors. Each frame is checksum-verified and its duties clamped to the PWM period (100). Valid frames are presented to the PWM stage as stable sign/duty registers with a `load` strobe; while `load` is high, the PWM stage must not capture.

## Interface
- `DUTY_MAX`, 7'd100, clamp ceiling for duty fields; equals the PWM stage period.
- `CSUM_KEY`, 8'hA5, checksum XOR key.
- `WDT_CYCLES`, 32'd12_000_000, watchdog timeout in clk cycles (used only with the watchdog macro).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `spi_sck` in 1: SPI clock, asynchronous, mode 0.
- `spi_cs_n` in 1: chip select, asynchronous, active-low.
- `spi_mosi` in 1: serial data, asynchronous, MSB first.
- `motor1_sign` out 1: motor 1 direction.
- `motor1_upperlimit` out 7: motor 1 duty, 0..DUTY_MAX.
- `motor2_sign` out 1: motor 2 direction.
- `motor2_upperlimit` out 7: motor 2 duty, 0..DUTY_MAX.
- `load` out 1: high while the motor outputs are being updated; PWM stage captures only when low.
- `cmd_valid` out 1: sticky; set by the first committed frame after reset.
- `frame_err` out 1: one-cycle pulse on a discarded frame.
- `err_count` out 8: count of discarded frames, saturates at 255.
- `wdt_trip` out 1: watchdog expired and no valid frame since.

## Operation
- `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer.
- Edges are detected on the synchronized signals against a third registered copy.
- Frame format, MSB first:
  - byte0 = {m1_sign, m1_duty[6:0]}
  - byte1 = {m2_sign, m2_duty[6:0]}
  - byte2 = byte0 ^ byte1 ^ CSUM_KEY
- FSM states: IDLE, SHIFT, CHECK, COMMIT, HOLD.
- IDLE: on a `cs_n` falling edge, clear the 24-bit shift register and the 5-bit bit counter, then go to SHIFT. If `cs_n` is already low when reset deasserts, the block ignores it until a high-then-low transition.
- SHIFT: on each `sck` rising edge, shift in `mosi` and increment the bit counter. The counter saturates at 25, which marks overrun. On a `cs_n` rising edge, go to CHECK.
- CHECK, one cycle:
  - Valid frame: bit count == 24 and the checksum matches. Go to COMMIT.
  - Otherwise: pulse `frame_err`, increment `err_count` (saturating), go to IDLE.
- COMMIT, one cycle: `load`=1. Output registers take the new signs and clamped duties. A duty of 101..127 becomes DUTY_MAX; 0..100 passes unchanged. Set `cmd_valid`. Go to HOLD.
- HOLD, one cycle: `load`=1. Go to IDLE.
- The shift register and counter are ignored outside SHIFT.
- Reset mid-frame: the frame is aborted, outputs return to reset values, and nothing is committed.
- Reset values: both signs 0, both duties 0, `load` 0, `cmd_valid` 0, `frame_err` 0, `err_count` 0, `wdt_trip` 0. FSM resets to IDLE.

## Timing
- Requirement on the host: SCK high and low phases must each last at least 3 clk periods. CS high time between frames must be at least 6 clk periods.
- Commit latency: `load` rises exactly 4 clk cycles after the first clk edge at which `spi_cs_n` is sampled high at the pin. The cycles are: sync1, sync2, edge-detect, then CHECK; COMMIT is the 4th.
- New output values are visible on the edge ending COMMIT.
- `load` is high for exactly 2 cycles (COMMIT, HOLD). Outputs never change while `load`=0.
- `frame_err` rises in the CHECK cycle, 3 cycles after CS is sampled high, and lasts 1 cycle.

## Configuration
- Macro: `MOTOR_CMD_WDT_EN`.
- Defined:
  - A 32-bit counter clears on every COMMIT and otherwise increments in every cycle.
  - When the counter reaches WDT_CYCLES and the FSM is in IDLE, the FSM enters COMMIT with both duties forced to 0; the signs are unchanged.
  - That COMMIT produces a normal 2-cycle `load` pulse, sets `wdt_trip`, and clears the counter. It does not set `cmd_valid`.
  - A pending timeout is deferred while the FSM is not in IDLE. A frame that reaches COMMIT clears the pending timeout.
  - The next valid frame clears `wdt_trip`.
- Undefined: no watchdog counter. `wdt_trip` is tied to 0 and the last committed values are held indefinitely.

## Test plan
- Valid frame 8'h32, 8'hC5, csum → motor1 sign 0, duty 50; motor2 sign 1, duty 69. `load` high for 2 cycles, 4 cycles after CS rises. `cmd_valid`=1.
- Duty field 7'h7F on both motors → both duties clamp to 100. Duty exactly 100 passes unchanged.
- Bad checksum; then 23-bit frame; then 26-bit frame → three `frame_err` pulses, `err_count`=3, outputs unchanged, `load` stays 0.
- Reset asserted after 12 bits of a frame → outputs 0, no commit. The next full valid frame commits normally.
- With `MOTOR_CMD_WDT_EN` and WDT_CYCLES=1000: valid frame with duties 60/60, then idle 1000 cycles → duties 0/0, signs kept, `load` 2-cycle pulse, `wdt_trip`=1. The next valid frame clears `wdt_trip`.
- 300 consecutive bad frames → `err_count` holds at 255.
